ahfp_add_pipe: RTL

Pipelined, parametrised floating-point adder/subtractor, the multi-cycle successor to the combinational `ahfp_add`. It is packaged as a Nios II extended multi-cycle custom instruction (`start`/`done`, `n` selects add or subtract) and accepts one operation per enabled cycle. Results arrive in issue order after a fixed latency. Defaults give IEEE-754 single precision with flush-to-zero denormals.

---
 rtl/ahfp_pkg.sv | 41 ++++
 rtl/ahfp_lzc.sv | 17 +
 rtl/ahfp_add_pipe.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahfp_pkg.sv
// Shared constants, types and helper functions for the ahfp floating-point adder family.
package ahfp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int FP_W_DEF  = 1 + EXP_W_DEF + MAN_W_DEF;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } fp_cls_e;

    // Control sideband carried alongside the datapath through every stage.
    typedef struct packed {
        logic valid;
        logic special;
        logic sign;
    } stage_ctl_t;

    function automatic int bias(input int exp_w);
        return 2 ** (exp_w - 1) - 1;
    endfunction

    function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [63:0] inf_word(input logic sign, input int exp_w, input int man_w);
        return ({63'd0, sign} << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
    endfunction

    function automatic fp_cls_e classify(input logic exp_zero, input logic exp_ones,
                                         input logic frac_zero);
        if (exp_zero) return CLS_ZERO;
        if (!exp_ones) return CLS_NORMAL;
        return frac_zero ? CLS_INF : CLS_NAN;
    endfunction

endpackage

// File: rtl/ahfp_lzc.sv
// Leading-zero counter; an all-zero input reports W.
module ahfp_lzc #(
    parameter int W     = 27,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     value,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CNT_W'(W - 1 - i);
        end
    end

endmodule

// File: rtl/ahfp_add_pipe.sv
// Four-stage pipelined floating-point add/subtract custom instruction (flush-to-zero).
// Define AHFP_ADD_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module ahfp_add_pipe
    import ahfp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic                   start,
    input  logic                   n,
    input  logic [EXP_W+MAN_W:0]   dataa,
    input  logic [EXP_W+MAN_W:0]   datab,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   done
);

    localparam int FP_W    = 1 + EXP_W + MAN_W;
    localparam int MW4     = MAN_W + 4;
    localparam int XW      = EXP_W + 2;
    localparam int LZ_W    = $clog2(MW4 + 1);
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    localparam logic [FP_W-1:0] QNAN  = FP_W'(qnan_word(EXP_W, MAN_W));
    localparam logic [FP_W-1:0] INF_P = FP_W'(inf_word(1'b0, EXP_W, MAN_W));
    localparam logic [FP_W-1:0] INF_N = FP_W'(inf_word(1'b1, EXP_W, MAN_W));

    typedef struct packed {
        logic [EXP_W-1:0] x_exp;
        logic [MAN_W:0]   x_man;
        logic [MAN_W:0]   y_man;
        logic [EXP_W-1:0] diff;
        logic             eff_sub;
        logic [FP_W-1:0]  sp_word;
    } s1_t;

    typedef struct packed {
        logic [EXP_W-1:0] x_exp;
        logic [MW4-1:0]   x_ext;
        logic [MW4-1:0]   y_al;
        logic             eff_sub;
        logic [FP_W-1:0]  sp_word;
    } s2_t;

    typedef struct packed {
        logic [EXP_W-1:0] x_exp;
        logic [MW4:0]     sum;
        logic [FP_W-1:0]  sp_word;
    } s3_t;

    typedef struct packed {
        logic signed [XW-1:0] ex;
        logic [MW4-1:0]       man;
        logic                 zero;
        logic [FP_W-1:0]      sp_word;
    } s4_t;

    s1_t n1, s1;
    s2_t n2, s2;
    s3_t n3, s3;
    s4_t n4, s4;
    stage_ctl_t c1, c2, c3, c4;
    logic n1_special, n1_sign;

    // ---------------- S1: unpack, specials, swap ----------------
    logic             a_sign, b_sign, a_ge;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    fp_cls_e          a_cls, b_cls;

    assign a_sign = dataa[FP_W-1];
    assign b_sign = datab[FP_W-1] ^ n;
    assign a_exp  = dataa[FP_W-2 -: EXP_W];
    assign b_exp  = datab[FP_W-2 -: EXP_W];
    assign a_frac = dataa[MAN_W-1:0];
    assign b_frac = datab[MAN_W-1:0];
    assign a_cls  = classify(a_exp == '0, &a_exp, a_frac == '0);
    assign b_cls  = classify(b_exp == '0, &b_exp, b_frac == '0);
    assign a_ge   = {a_exp, a_frac} >= {b_exp, b_frac};

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path can infer a latch.
        n1_special = 1'b1;
        n1.sp_word = QNAN;
        if (a_cls == CLS_NAN || b_cls == CLS_NAN) begin
            n1.sp_word = QNAN;
        end else if (a_cls == CLS_INF && b_cls == CLS_INF) begin
            n1.sp_word = (a_sign != b_sign) ? QNAN : (a_sign ? INF_N : INF_P);
        end else if (a_cls == CLS_INF) begin
            n1.sp_word = a_sign ? INF_N : INF_P;
        end else if (b_cls == CLS_INF) begin
            n1.sp_word = b_sign ? INF_N : INF_P;
        end else if (a_cls == CLS_ZERO && b_cls == CLS_ZERO) begin
            n1.sp_word = {a_sign & b_sign, {(FP_W-1){1'b0}}};
        end else if (a_cls == CLS_ZERO) begin
            n1.sp_word = {b_sign, b_exp, b_frac};
        end else if (b_cls == CLS_ZERO) begin
            n1.sp_word = {a_sign, a_exp, a_frac};
        end else begin
            n1_special = 1'b0;
        end
        n1.x_exp   = a_ge ? a_exp : b_exp;
        n1.x_man   = a_ge ? {1'b1, a_frac} : {1'b1, b_frac};
        n1.y_man   = a_ge ? {1'b1, b_frac} : {1'b1, a_frac};
        n1.diff    = a_ge ? a_exp - b_exp : b_exp - a_exp;
        n1.eff_sub = a_sign ^ b_sign;
        n1_sign    = a_ge ? a_sign : b_sign;
    end

    // ---------------- S2: align Y with guard/round/sticky ----------------
    logic [MW4-1:0] y_ext, y_shift;
    logic           y_lost;

    assign y_ext   = {s1.y_man, 3'b000};
    assign y_shift = y_ext >> s1.diff;
    assign y_lost  = |(y_ext & ((MW4'(1) << s1.diff) - MW4'(1)));

    always_comb begin
        n2.x_exp   = s1.x_exp;
        n2.x_ext   = {s1.x_man, 3'b000};
        n2.eff_sub = s1.eff_sub;
        n2.sp_word = s1.sp_word;
        if (int'(s1.diff) >= MAN_W + 3) n2.y_al = {{(MW4-1){1'b0}}, 1'b1};
        else                            n2.y_al = {y_shift[MW4-1:1], y_shift[0] | y_lost};
    end

    // ---------------- S3: magnitude add/subtract ----------------
    always_comb begin
        n3.x_exp   = s2.x_exp;
        n3.sp_word = s2.sp_word;
        n3.sum     = s2.eff_sub ? {1'b0, s2.x_ext} - {1'b0, s2.y_al}
                                : {1'b0, s2.x_ext} + {1'b0, s2.y_al};
    end

    // ---------------- S4: normalise ----------------
    logic [LZ_W-1:0] lz;

    ahfp_lzc #(.W(MW4)) u_lzc (
        .value (s3.sum[MW4-1:0]),
        .count (lz)
    );

    always_comb begin
        n4.sp_word = s3.sp_word;
        n4.zero    = (s3.sum == '0);
        if (s3.sum[MW4]) begin
            n4.man = {s3.sum[MW4:2], s3.sum[1] | s3.sum[0]};
            n4.ex  = XW'(s3.x_exp) + XW'(1);
        end else begin
            n4.man = s3.sum[MW4-1:0] << lz;
            n4.ex  = XW'(s3.x_exp) - XW'(lz);
        end
    end

    // ---------------- Output: round, range check, pack ----------------
    logic signed [XW-1:0] exp_r;
    logic [MAN_W-1:0]     frac_r;
    logic [FP_W-1:0]      res_word;

`ifdef AHFP_ADD_RNE_EN
    logic             rnd_inc;
    logic [MAN_W+1:0] man_r;

    always_comb begin
        exp_r   = s4.ex;
        rnd_inc = s4.man[2] & (s4.man[1] | s4.man[0] | s4.man[3]);
        man_r   = {1'b0, s4.man[MW4-1:3]} + (MAN_W+2)'(rnd_inc);
        if (man_r[MAN_W+1]) begin
            frac_r = man_r[MAN_W:1];
            exp_r  = exp_r + XW'(1);
        end else begin
            frac_r = man_r[MAN_W-1:0];
        end
    end
`else
    logic unused_grs;

    assign unused_grs = ^{s4.man[MW4-1], s4.man[2:0]};

    always_comb begin
        exp_r  = s4.ex;
        frac_r = s4.man[MW4-2:3];
    end
`endif

    always_comb begin
        if (c4.special)                 res_word = s4.sp_word;
        else if (s4.zero)               res_word = '0;
        else if (int'(exp_r) >= EXP_MAX) res_word = c4.sign ? INF_N : INF_P;
        else if (int'(exp_r) <= 0)      res_word = {c4.sign, {(FP_W-1){1'b0}}};
        else                            res_word = {c4.sign, exp_r[EXP_W-1:0], frac_r};
    end

    // ---------------- Registers ----------------
    // NOTE: sequential state uses non-blocking assignments so each stage samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c1     <= '0;
            c2     <= '0;
            c3     <= '0;
            c4     <= '0;
            done   <= 1'b0;
            result <= '0;
        end else if (clk_en) begin
            c1   <= '{valid: start, special: n1_special, sign: n1_sign};
            c2   <= c1;
            c3   <= c2;
            c4   <= c3;
            done <= c4.valid;
            if (c4.valid) result <= res_word;
        end
    end

    // NOTE: datapath registers carry no reset; the valid bits alone decide what reaches result.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (start) s1 <= n1;
            s2 <= n2;
            s3 <= n3;
            s4 <= n4;
        end
    end

endmodule
